// File: rtl/instruction_fetch.sv
// ============================================================================
// instruction_fetch : program counter, instruction-memory req/ack fetch, held
//                     instruction register for the decoder, stall and redirect
// Revision: 1.0
// ============================================================================
`default_nettype none

module instruction_fetch #(
  parameter int ADDR_W = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [15:0]       mem_rdata,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [15:0]       inst,
  output logic              s,
  output logic              inst_valid,
  output logic [ADDR_W-1:0] inst_pc,
  output logic [ADDR_W-1:0] pc_next
);

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] PC_STEP = 1;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [3:0]        opcode;

  // mem_req is a separate register so it can stay low for the cycle after
  // reset even though the state is already FETCH; stale acks then fall away.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      mem_req    <= 1'b0;
      inst       <= 16'h0000;
      inst_pc    <= '0;
      inst_valid <= 1'b0;
    end else if (redirect) begin
      state      <= FETCH;
      pc         <= redirect_pc;
      mem_req    <= 1'b1;
      inst_valid <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (mem_req && mem_ack) begin
            inst       <= mem_rdata;
            inst_pc    <= pc;
            pc         <= pc + PC_STEP;
            inst_valid <= 1'b1;
            mem_req    <= 1'b0;
            state      <= HOLD;
          end else begin
            mem_req <= 1'b1;
          end
        end
        HOLD: begin
          if (!stall) begin
            inst_valid <= 1'b0;
            mem_req    <= 1'b1;
            state      <= FETCH;
          end
        end
        default: begin
          state   <= FETCH;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

  assign mem_addr = pc;
  assign pc_next  = pc;
  assign opcode   = inst[15:12];

  // Register-form opcodes (ALU reg-reg and load/store/jump reg) carry no immediate.
  assign s = inst_valid && !((opcode == 4'b0000) || (opcode == 4'b0100));

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch.sv
// ============================================================================
// tb_instruction_fetch : directed self-checking bench for instruction_fetch
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_instruction_fetch;

  logic        clk;
  logic        reset;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [15:0] inst;
  logic        s;
  logic        inst_valid;
  logic [15:0] inst_pc;
  logic [15:0] pc_next;

  int total;
  int passed;

  instruction_fetch #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .reset(reset),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .inst(inst), .s(s), .inst_valid(inst_valid), .inst_pc(inst_pc), .pc_next(pc_next)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic chk_fetch(input string tag, input logic [15:0] addr);
    chk({tag, "_req"}, 32'(mem_req), 32'd1);
    chk({tag, "_addr"}, 32'(mem_addr), 32'(addr));
    chk({tag, "_valid"}, 32'(inst_valid), 32'd0);
  endtask

  task automatic chk_inst(input string tag, input logic [15:0] w, input logic [15:0] pc,
                          input logic sv);
    chk({tag, "_inst"}, 32'(inst), 32'(w));
    chk({tag, "_pc"}, 32'(inst_pc), 32'(pc));
    chk({tag, "_s"}, 32'(s), 32'(sv));
    chk({tag, "_valid"}, 32'(inst_valid), 32'd1);
    chk({tag, "_req"}, 32'(mem_req), 32'd0);
  endtask

  initial begin
    total = 0;
    passed = 0;
    reset = 1'b0; mem_ack = 1'b0; mem_rdata = 16'h0000;
    stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;

    // reset state
    step();
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst", 32'(inst), 32'h0);
    chk("rst_inst_pc", 32'(inst_pc), 32'h0);
    chk("rst_pc_next", 32'(pc_next), 32'h0);
    chk("rst_s", 32'(s), 32'd0);

    reset = 1'b1;
    step();
    chk_fetch("f0", 16'h0000);

    // back-to-back single-cycle acks
    mem_ack = 1'b1; mem_rdata = 16'h0521;
    step();
    chk_inst("i0", 16'h0521, 16'h0000, 1'b0);
    chk("i0_pc_next", 32'(pc_next), 32'h1);
    mem_rdata = 16'hFFFF;  // ack while idle must be ignored
    step();
    chk_fetch("f1", 16'h0001);
    chk("f1_inst_kept", 32'(inst), 32'h0521);
    chk("f1_s_invalid", 32'(s), 32'd0);
    mem_rdata = 16'h5103;
    step();
    chk_inst("i1", 16'h5103, 16'h0001, 1'b1);
    mem_ack = 1'b0;
    step();
    chk_fetch("f2", 16'h0002);
    mem_ack = 1'b1; mem_rdata = 16'h4C05;
    step();
    chk_inst("i2", 16'h4C05, 16'h0002, 1'b0);
    mem_ack = 1'b0;
    step();
    chk_fetch("f3", 16'h0003);
    mem_ack = 1'b1; mem_rdata = 16'h7000;
    step();
    chk_inst("i3", 16'h7000, 16'h0003, 1'b1);
    mem_ack = 1'b0;

    // slow memory: request held for 4 cycles at address 4
    for (int k = 0; k < 4; k++) begin
      step();
      chk_fetch("slow", 16'h0004);
    end
    mem_ack = 1'b1; mem_rdata = 16'h1111;
    step();
    chk_inst("i4", 16'h1111, 16'h0004, 1'b1);
    mem_ack = 1'b0;
    step();
    chk_fetch("f5", 16'h0005);
    mem_ack = 1'b1; mem_rdata = 16'h2222;
    step();
    chk_inst("i5", 16'h2222, 16'h0005, 1'b1);
    mem_ack = 1'b0;
    step();
    chk_fetch("f6", 16'h0006);
    mem_ack = 1'b1; mem_rdata = 16'h3333;
    step();
    chk_inst("i6", 16'h3333, 16'h0006, 1'b1);
    mem_ack = 1'b0;
    step();
    chk_fetch("f7", 16'h0007);

    // stall holds the instruction at pc 7
    stall = 1'b1; mem_ack = 1'b1; mem_rdata = 16'hB20A;
    step();
    chk_inst("i7", 16'hB20A, 16'h0007, 1'b1);
    mem_ack = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk_inst("stall", 16'hB20A, 16'h0007, 1'b1);
    end
    stall = 1'b0;
    step();
    chk_fetch("f8", 16'h0008);

    // redirect coincident with ack discards the word
    redirect = 1'b1; redirect_pc = 16'h0040; mem_ack = 1'b1; mem_rdata = 16'h1234;
    step();
    chk_fetch("redir", 16'h0040);
    chk("redir_inst", 32'(inst), 32'hB20A);
    chk("redir_pc_next", 32'(pc_next), 32'h0040);
    redirect = 1'b0; mem_rdata = 16'h0ABC;
    step();
    chk_inst("i40", 16'h0ABC, 16'h0040, 1'b0);
    mem_ack = 1'b0;

    // redirect beats stall in HOLD
    stall = 1'b1; redirect = 1'b1; redirect_pc = 16'hFFFF;
    step();
    chk_fetch("redir_hold", 16'hFFFF);
    stall = 1'b0; redirect = 1'b0;

    // wrap at top of address space
    mem_ack = 1'b1; mem_rdata = 16'h8001;
    step();
    chk_inst("iffff", 16'h8001, 16'hFFFF, 1'b1);
    chk("wrap_pc_next", 32'(pc_next), 32'h0000);
    mem_ack = 1'b0;
    step();
    chk_fetch("wrap", 16'h0000);

    // reset in the middle of an outstanding request
    redirect = 1'b1; redirect_pc = 16'h0010;
    step();
    chk_fetch("f10", 16'h0010);
    redirect = 1'b0;
    step();
    chk_fetch("f10w", 16'h0010);
    reset = 1'b0; mem_ack = 1'b1; mem_rdata = 16'hDEAD;
    step();
    chk("mr_req", 32'(mem_req), 32'd0);
    chk("mr_valid", 32'(inst_valid), 32'd0);
    chk("mr_pc_next", 32'(pc_next), 32'h0000);
    reset = 1'b1;  // stale ack still present on the first cycle out of reset
    step();
    chk_fetch("mr_f0", 16'h0000);
    chk("mr_inst", 32'(inst), 32'h0000);
    mem_rdata = 16'h4000;
    step();
    chk_inst("mr_i0", 16'h4000, 16'h0000, 1'b0);
    mem_ack = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
